payment_controller: RTL and testbench

PAYMENT_CONTROLLER -- requirements
Module: payment_controller

---
 rtl/payment_controller.sv | 138 +++++++++++++
 tb/tb_payment_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/payment_controller.sv
// Coin-operated payment session controller: collects coins against a latched
// price, then vends or refunds through a change-dispenser handshake.
module payment_controller #(
    parameter int MONEY_W        = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] coin_value,
    input  logic [MONEY_W-1:0] price,
    input  logic               cancel,
    input  logic               change_ready,
    input  logic               change_done,
    output logic               change_req,
    output logic [MONEY_W-1:0] change_amount,
    output logic [MONEY_W-1:0] credit,
    output logic [2:0]         state,
    output logic               sale_ok,
    output logic               refunded,
    output logic               coin_reject
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        REFUND  = 3'd2,
        VEND    = 3'd3,
        THANKS  = 3'd4
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             stateReg;
    logic [MONEY_W-1:0] priceReg;
    logic [CNT_W-1:0]   timeoutCnt;
    logic               handshakeDone;

    logic [MONEY_W-1:0] coinAdd;
    logic [MONEY_W:0]   sum;
    logic               overflow;
    logic               priceMet;
    logic               timeoutHit;
    logic [MONEY_W-1:0] vendChange;

    assign state      = stateReg;
    assign coinAdd    = coin_valid ? coin_value : '0;
    assign sum        = {1'b0, credit} + {1'b0, coinAdd};
    assign overflow   = sum[MONEY_W];
    assign priceMet   = sum >= {1'b0, priceReg};
    assign timeoutHit = (timeoutCnt == TO_LAST) && !coin_valid;
    assign vendChange = sum[MONEY_W-1:0] - priceReg;

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg      <= IDLE;
            credit        <= '0;
            change_amount <= '0;
            change_req    <= 1'b0;
            sale_ok       <= 1'b0;
            refunded      <= 1'b0;
            coin_reject   <= 1'b0;
            priceReg      <= '0;
            timeoutCnt    <= '0;
            handshakeDone <= 1'b0;
        end else begin
            sale_ok     <= 1'b0;
            refunded    <= 1'b0;
            coin_reject <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (coin_valid && coin_value != '0) begin
                        credit     <= coin_value;
                        priceReg   <= price;
                        timeoutCnt <= '0;
                        stateReg   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (overflow) begin
                        coin_reject   <= 1'b1;
                        change_amount <= credit;
                        stateReg      <= REFUND;
                    end else begin
                        credit <= sum[MONEY_W-1:0];
                        if (coin_valid)
                            timeoutCnt <= '0;
                        else
                            timeoutCnt <= timeoutCnt + CNT_W'(1);
                        if (cancel) begin
                            change_amount <= sum[MONEY_W-1:0];
                            stateReg      <= REFUND;
                        end else if (priceMet) begin
                            change_amount <= vendChange;
                            stateReg      <= VEND;
                        end else if (timeoutHit) begin
                            change_amount <= credit;
                            stateReg      <= REFUND;
                        end
                    end
                end
                REFUND, VEND: begin
                    coin_reject <= coin_valid;
                    // change_done only counts once the request was taken
                    if (change_amount == '0 || (handshakeDone && change_done)) begin
                        stateReg      <= THANKS;
                        sale_ok       <= (stateReg == VEND);
                        refunded      <= (stateReg == REFUND);
                        credit        <= '0;
                        change_amount <= '0;
                        handshakeDone <= 1'b0;
                    end else if (!handshakeDone) begin
                        if (!change_req) begin
                            change_req <= 1'b1;
                        end else if (change_ready) begin
                            change_req    <= 1'b0;
                            handshakeDone <= 1'b1;
                        end
                    end
                end
                THANKS: begin
                    coin_reject <= coin_valid;
                    stateReg    <= IDLE;
                end
                default: begin
                    stateReg      <= IDLE;
                    credit        <= '0;
                    change_amount <= '0;
                    change_req    <= 1'b0;
                    timeoutCnt    <= '0;
                    handshakeDone <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_payment_controller.sv
// Directed vector bench for payment_controller (MONEY_W=8, TIMEOUT_CYCLES=16).
module tb_payment_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       coinValid = 1'b0;
    logic [7:0] coinValue = '0;
    logic [7:0] price = '0;
    logic       cancel = 1'b0;
    logic       changeReady = 1'b0;
    logic       changeDone = 1'b0;
    logic       changeReq;
    logic [7:0] changeAmount;
    logic [7:0] credit;
    logic [2:0] state;
    logic       saleOk;
    logic       refunded;
    logic       coinReject;

    int checks = 0;
    int errors = 0;

    payment_controller #(.MONEY_W(8), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock),
        .reset(reset),
        .coin_valid(coinValid),
        .coin_value(coinValue),
        .price(price),
        .cancel(cancel),
        .change_ready(changeReady),
        .change_done(changeDone),
        .change_req(changeReq),
        .change_amount(changeAmount),
        .credit(credit),
        .state(state),
        .sale_ok(saleOk),
        .refunded(refunded),
        .coin_reject(coinReject)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       rst;
        logic       cv;
        logic [7:0] cval;
        logic [7:0] pr;
        logic       can;
        logic       rdy;
        logic       dn;
        logic [2:0] eSt;
        logic [7:0] eCr;
        logic       eReq;
        logic [7:0] eAmt;
        logic       eSale;
        logic       eRef;
        logic       eRej;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r, logic cv, logic [7:0] cval,
                                logic [7:0] pr, logic can, logic rdy, logic dn,
                                logic [2:0] st, logic [7:0] cr, logic rq,
                                logic [7:0] amt, logic so, logic rf, logic rj);
        vec_t v;
        v.name = n; v.rst = r; v.cv = cv; v.cval = cval; v.pr = pr;
        v.can = can; v.rdy = rdy; v.dn = dn;
        v.eSt = st; v.eCr = cr; v.eReq = rq; v.eAmt = amt;
        v.eSale = so; v.eRef = rf; v.eRej = rj;
        return v;
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // One cycle: drive on the falling edge, sample 1ns after the rising edge.
    task automatic apply(vec_t v);
        logic [22:0] act;
        logic [22:0] exp;
        @(negedge clock);
        reset = v.rst; coinValid = v.cv; coinValue = v.cval; price = v.pr;
        cancel = v.can; changeReady = v.rdy; changeDone = v.dn;
        @(posedge clock);
        #1;
        act = {state, credit, changeReq, changeAmount, saleOk, refunded, coinReject};
        exp = {v.eSt, v.eCr, v.eReq, v.eAmt, v.eSale, v.eRef, v.eRej};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d cr=%0d req=%b amt=%0d sale=%b ref=%b rej=%b expected st=%0d cr=%0d req=%b amt=%0d sale=%b ref=%b rej=%b",
                     v.name, state, credit, changeReq, changeAmount, saleOk, refunded, coinReject,
                     v.eSt, v.eCr, v.eReq, v.eAmt, v.eSale, v.eRef, v.eRej);
        end
    endtask

    task automatic idleCycle();
        @(negedge clock);
        reset = 1'b0; coinValid = 1'b0; coinValue = '0;
        cancel = 1'b0; changeReady = 1'b0; changeDone = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int waited;
        logic seen;

        //               name        rst cv cval pr  can rdy dn  st cr  rq amt so rf rj
        vecs.push_back(mk("reset",    1, 0,   0,  0, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0));
        // sale with change 3
        vecs.push_back(mk("v_coin5a", 0, 1,   5,  7, 0,  0,  0,  1,  5, 0,  0, 0, 0, 0));
        vecs.push_back(mk("v_coin5b", 0, 1,   5,  7, 0,  0,  0,  3, 10, 0,  3, 0, 0, 0));
        vecs.push_back(mk("v_req",    0, 0,   0,  7, 0,  0,  0,  3, 10, 1,  3, 0, 0, 0));
        vecs.push_back(mk("v_earlyDn",0, 0,   0,  7, 0,  0,  1,  3, 10, 1,  3, 0, 0, 0));
        vecs.push_back(mk("v_ready",  0, 0,   0,  7, 0,  1,  0,  3, 10, 0,  3, 0, 0, 0));
        vecs.push_back(mk("v_wait",   0, 0,   0,  7, 0,  0,  0,  3, 10, 0,  3, 0, 0, 0));
        vecs.push_back(mk("v_done",   0, 0,   0,  7, 0,  0,  1,  4,  0, 0,  0, 1, 0, 0));
        vecs.push_back(mk("v_idle",   0, 0,   0,  7, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0));
        // cancel together with a coin; price change mid-session is ignored
        vecs.push_back(mk("c_coin2",  0, 1,   2, 10, 0,  0,  0,  1,  2, 0,  0, 0, 0, 0));
        vecs.push_back(mk("c_coin3",  0, 1,   3,  1, 0,  0,  0,  1,  5, 0,  0, 0, 0, 0));
        vecs.push_back(mk("c_cancel", 0, 1,   1,  1, 1,  0,  0,  2,  6, 0,  6, 0, 0, 0));
        vecs.push_back(mk("c_req",    0, 0,   0,  1, 1,  0,  0,  2,  6, 1,  6, 0, 0, 0));
        vecs.push_back(mk("c_ready",  0, 0,   0,  1, 0,  1,  0,  2,  6, 0,  6, 0, 0, 0));
        vecs.push_back(mk("c_done",   0, 0,   0,  1, 0,  0,  1,  4,  0, 0,  0, 0, 1, 0));
        vecs.push_back(mk("c_idle",   0, 0,   0,  1, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0));
        // overflow reject
        vecs.push_back(mk("o_c200",   0, 1, 200,255, 0,  0,  0,  1,200, 0,  0, 0, 0, 0));
        vecs.push_back(mk("o_c50",    0, 1,  50,255, 0,  0,  0,  1,250, 0,  0, 0, 0, 0));
        vecs.push_back(mk("o_c10",    0, 1,  10,255, 0,  0,  0,  2,250, 0,250, 0, 0, 1));
        vecs.push_back(mk("o_rejRef", 0, 1,   3,255, 0,  0,  0,  2,250, 1,250, 0, 0, 1));
        vecs.push_back(mk("o_ready",  0, 0,   0,255, 0,  1,  0,  2,250, 0,250, 0, 0, 0));
        vecs.push_back(mk("o_done",   0, 0,   0,255, 0,  0,  1,  4,  0, 0,  0, 0, 1, 0));
        vecs.push_back(mk("o_idle",   0, 0,   0,255, 0,  0,  0,  0,  0, 0,  0, 0, 0, 0));
        // exact payment, no change
        vecs.push_back(mk("e_coin5",  0, 1,   5,  5, 0,  0,  0,  1,  5, 0,  0, 0, 0, 0));
        vecs.push_back(mk("e_vend",   0, 0,   0,  5, 0,  0,  0,  3,  5, 0,  0, 0, 0, 0));
        vecs.push_back(mk("e_thanks", 0, 0,   0,  5, 0,  0,  0,  4,  0, 0,  0, 1, 0, 0));
        vecs.push_back(mk("e_rejThx", 0, 1,   4,  5, 0,  0,  0,  0,  0, 0,  0, 0, 0, 1));
        vecs.push_back(mk("e_zeroCn", 0, 1,   0,  5, 1,  0,  0,  0,  0, 0,  0, 0, 0, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // Timeout: refund exactly 16 cycles after the coin edge.
        apply(mk("t_reset", 1, 0, 0, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk("t_coin4", 0, 1, 4, 50, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0));
        waited = 0;
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            idleCycle();
            if (state == 3'd2) begin
                seen = 1'b1;
                waited = n;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout_wait: got no refund within 40 cycles, expected 16");
        end else begin
            check("timeout_cycles", waited, 16);
            check("timeout_amount", changeAmount, 4);
            check("timeout_credit", credit, 4);
        end

        // Reset while a change request is pending drops it silently.
        apply(mk("r_reset", 1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk("r_coin5a", 0, 1, 5, 7, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0));
        apply(mk("r_coin5b", 0, 1, 5, 7, 0, 0, 0, 3, 10, 0, 3, 0, 0, 0));
        apply(mk("r_req", 0, 0, 0, 7, 0, 0, 0, 3, 10, 1, 3, 0, 0, 0));
        apply(mk("r_hit", 1, 1, 9, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        apply(mk("r_late1", 0, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        apply(mk("r_late2", 0, 0, 0, 7, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
